// File: rtl/threshold_config_master_pkg.sv
// Shared definitions for the threshold-configuration link, common to the
// initiator (threshold_config_master) and the threshold controller.
//   - mode character range "A".."G" and the direction command bytes
//   - response status codes
//   - initiator state encoding
//   - captured request struct and small helper functions
package threshold_config_master_pkg;

  // Valid mode characters are the contiguous ASCII range MODE_A..MODE_G.
  localparam logic [7:0] MODE_A  = 8'h41;  // "A"
  localparam logic [7:0] MODE_G  = 8'h47;  // "G"
  localparam logic [7:0] CMD_INC = 8'h77;  // "w"
  localparam logic [7:0] CMD_DEC = 8'h73;  // "s"

  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_ECHO_ERR = 2'd1,
    RSP_TIMEOUT  = 2'd2,
    RSP_BAD_MODE = 2'd3
  } rsp_status_e;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    SEND_MODE      = 3'd1,
    WAIT_MODE_ECHO = 3'd2,
    SEND_DIR       = 3'd3,
    WAIT_DIR_ECHO  = 3'd4,
    WAIT_LSB       = 3'd5,
    WAIT_MSB       = 3'd6,
    RESPOND        = 3'd7
  } state_e;

  typedef struct packed {
    logic [7:0] mode;
    logic       dir;
  } cfg_req_t;

  function automatic logic mode_valid(input logic [7:0] m);
    return (m >= MODE_A) && (m <= MODE_G);
  endfunction

  function automatic logic [7:0] dir_byte(input logic dir);
    return dir ? CMD_INC : CMD_DEC;
  endfunction

endpackage

// File: rtl/threshold_config_master_uart.sv
// 8N1 UART used for the threshold-configuration link.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   data_tx/start_tx byte to send and its one-cycle launch strobe
//   idle_ready_tx   high while the transmitter can accept a byte
//   tx              serial output, idle high
//   rx              serial input (asynchronous, synchronised here)
//   data_rx/data_ready_rx received byte and its one-cycle valid pulse
module threshold_config_master_uart #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_tx,
  input  logic       start_tx,
  output logic       idle_ready_tx,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] data_rx,
  output logic       data_ready_rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------- transmitter ----------------
  // Frame is {stop, data, start} shifted out LSB first; ones shift in behind
  // it so the line rests high once the frame is gone.
  logic [9:0]    tsh_q;
  logic [3:0]    tbit_q;
  logic [CW-1:0] tcnt_q;
  logic          tbusy_q;

  assign idle_ready_tx = !tbusy_q;
  assign tx            = tsh_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      tsh_q   <= '1;
      tbit_q  <= '0;
      tcnt_q  <= '0;
      tbusy_q <= 1'b0;
    end else if (!tbusy_q) begin
      if (start_tx) begin
        tsh_q   <= {1'b1, data_tx, 1'b0};
        tbit_q  <= '0;
        tcnt_q  <= '0;
        tbusy_q <= 1'b1;
      end
    end else if (tcnt_q == FULL) begin
      tcnt_q <= '0;
      tsh_q  <= {1'b1, tsh_q[9:1]};
      if (tbit_q == 4'd9) tbusy_q <= 1'b0;
      else                tbit_q  <= tbit_q + 4'd1;
    end else begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e     rstate_q, rstate_d;
  logic          rx_m_q, rx_s_q;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [2:0]    rbit_q, rbit_d;
  logic [7:0]    rsh_q, rsh_d;
  logic          rdy_q, rdy_d;

  assign data_rx       = rsh_q;
  assign data_ready_rx = rdy_q;

  // Start bit is re-checked at its midpoint; every later bit is sampled one
  // full bit time on, i.e. mid-bit. A low stop bit drops the byte.
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    rbit_d   = rbit_q;
    rsh_d    = rsh_q;
    rdy_d    = 1'b0;
    unique case (rstate_q)
      RX_IDLE: begin
        rcnt_d = '0;
        if (!rx_s_q) rstate_d = RX_START;
      end
      RX_START: begin
        if (rcnt_q == HALF) begin
          rcnt_d   = '0;
          rbit_d   = '0;
          rstate_d = rx_s_q ? RX_IDLE : RX_DATA;
        end else rcnt_d = rcnt_q + 1'b1;
      end
      RX_DATA: begin
        if (rcnt_q == FULL) begin
          rcnt_d = '0;
          rsh_d  = {rx_s_q, rsh_q[7:1]};
          rbit_d = rbit_q + 3'd1;
          if (rbit_q == 3'd7) rstate_d = RX_STOP;
        end else rcnt_d = rcnt_q + 1'b1;
      end
      RX_STOP: begin
        if (rcnt_q == FULL) begin
          rdy_d    = rx_s_q;
          rstate_d = RX_IDLE;
        end else rcnt_d = rcnt_q + 1'b1;
      end
      default: rstate_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m_q   <= 1'b1;
      rx_s_q   <= 1'b1;
      rstate_q <= RX_IDLE;
      rcnt_q   <= '0;
      rbit_q   <= '0;
      rsh_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      rx_m_q   <= rx;
      rx_s_q   <= rx_m_q;
      rstate_q <= rstate_d;
      rcnt_q   <= rcnt_d;
      rbit_q   <= rbit_d;
      rsh_q    <= rsh_d;
      rdy_q    <= rdy_d;
    end
  end

endmodule

// File: rtl/threshold_config_master.sv
// Initiator for the threshold-configuration protocol: sends a mode byte,
// checks its echo, sends "w"/"s", checks that echo, then collects the
// updated threshold (two bytes for mode "A", one sign-extended byte otherwise).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake; req_mode ("A".."G"), req_dir (1 = "w")
//   rsp_valid            one-cycle response pulse
//   rsp_status/rsp_value result, held until the next pulse
//   rx, tx               serial link to the threshold controller
module threshold_config_master
  import threshold_config_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned CLKS_PER_BIT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_mode,
  input  logic        req_dir,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [15:0] rsp_value,
  input  logic        rx,
  output logic        tx
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e      state_q, state_d;
  cfg_req_t    req_q, req_d;
  logic [7:0]  lsb_q, lsb_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  rsp_status_e status_q, status_d;
  logic [15:0] value_q, value_d;

  logic       start_tx, idle_ready_tx, data_ready_rx;
  logic [7:0] data_tx, data_rx;
  logic       in_wait, to_hit, tx_go;

  threshold_config_master_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk          (clk),
    .rst          (rst),
    .data_tx      (data_tx),
    .start_tx     (start_tx),
    .idle_ready_tx(idle_ready_tx),
    .tx           (tx),
    .rx           (rx),
    .data_rx      (data_rx),
    .data_ready_rx(data_ready_rx)
  );

  assign in_wait    = state_q inside {WAIT_MODE_ECHO, WAIT_DIR_ECHO, WAIT_LSB, WAIT_MSB};
  // Counter value k means k full cycles already spent waiting; the next edge
  // would make it TIMEOUT_CYCLES.
  assign to_hit     = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign tx_go      = idle_ready_tx && !rst;
  assign data_tx    = (state_q == SEND_DIR) ? dir_byte(req_q.dir) : req_q.mode;
  assign rsp_valid  = (state_q == RESPOND);
  assign rsp_status = status_q;
  assign rsp_value  = value_q;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    lsb_d     = lsb_q;
    status_d  = status_q;
    value_d   = value_q;
    start_tx  = 1'b0;
    req_ready = (state_q == IDLE) && !rst;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_d.mode = req_mode;
          req_d.dir  = req_dir;
          if (mode_valid(req_mode)) begin
            state_d = SEND_MODE;
          end else begin
            state_d  = RESPOND;
            status_d = RSP_BAD_MODE;
            value_d  = '0;
          end
        end
      end
      SEND_MODE: begin
        if (tx_go) begin
          start_tx = 1'b1;
          state_d  = WAIT_MODE_ECHO;
        end
      end
      WAIT_MODE_ECHO: begin
        if (data_ready_rx) begin
          if (data_rx == req_q.mode) state_d = SEND_DIR;
          else begin
            state_d  = RESPOND;
            status_d = RSP_ECHO_ERR;
            value_d  = '0;
          end
        end
      end
      SEND_DIR: begin
        if (tx_go) begin
          start_tx = 1'b1;
          state_d  = WAIT_DIR_ECHO;
        end
      end
      WAIT_DIR_ECHO: begin
        if (data_ready_rx) begin
          if (data_rx == dir_byte(req_q.dir)) state_d = WAIT_LSB;
          else begin
            state_d  = RESPOND;
            status_d = RSP_ECHO_ERR;
            value_d  = '0;
          end
        end
      end
      WAIT_LSB: begin
        if (data_ready_rx) begin
          lsb_d = data_rx;
          if (req_q.mode == MODE_A) state_d = WAIT_MSB;
          else begin
            state_d  = RESPOND;
            status_d = RSP_OK;
            value_d  = {{8{data_rx[7]}}, data_rx};
          end
        end
      end
      WAIT_MSB: begin
        if (data_ready_rx) begin
          state_d  = RESPOND;
          status_d = RSP_OK;
          value_d  = {data_rx, lsb_q};
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A byte landing on the expiry cycle wins over the timeout.
    if (in_wait && !data_ready_rx && to_hit) begin
      state_d  = RESPOND;
      status_d = RSP_TIMEOUT;
      value_d  = '0;
    end
  end

  // Restarts on any state change (so on every WAIT entry) and on every byte.
  always_comb begin
    to_cnt_d = '0;
    if (in_wait && (state_d == state_q) && !data_ready_rx) to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      lsb_q    <= '0;
      to_cnt_q <= '0;
      status_q <= RSP_OK;
      value_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      lsb_q    <= lsb_d;
      to_cnt_q <= to_cnt_d;
      status_q <= status_d;
      value_q  <= value_d;
    end
  end

endmodule

// File: tb/tb_threshold_config_master.sv
// Bench for threshold_config_master: a behavioural threshold controller on the
// serial link, a scoreboard of expected responses, and a response monitor.
module tb_threshold_config_master;

  localparam int CPB = 8;
  localparam int TMO = 1000;
  localparam int CTL_NORMAL = 0, CTL_BAD_ECHO = 1, CTL_SILENT = 2, CTL_HANG = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_mode = 8'h00;
  logic        req_dir = 1'b0;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [15:0] rsp_value;
  logic        rx = 1'b1;
  logic        tx;

  threshold_config_master #(.TIMEOUT_CYCLES(TMO), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_dir(req_dir), .rsp_valid(rsp_valid),
    .rsp_status(rsp_status), .rsp_value(rsp_value), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] st; logic [15:0] val; } exp_t;

  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   rsp_cnt = 0, rsp_cyc = 0;
  bit   prev_vld = 0;
  bit   tx_low = 0;
  bit   lsb_wait = 0;
  int   ctl_mode = CTL_NORMAL;
  logic [15:0] reply = '0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [7:0] tx_log[$];
  logic [7:0] rxq[$];
  int   tx_cyc[$];

  // Controller threshold model: A is 16-bit unsigned, B..G signed bytes.
  int thr[7] = '{2599, 0, 16, 50, -12, -5, 100};
  int lo[7]  = '{0, -128, -128, -128, -12, -128, -128};
  int hi[7]  = '{65535, 127, 127, 127, 127, 127, 127};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT pulses rsp_valid.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      rsp_cyc = cyc;
      rsp_cnt++;
      chk("rsp_single_cycle", prev_vld, 0);
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp status=%0d value=%h expected no response", rsp_status, rsp_value);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_status", rsp_status, mon_e.st);
        chk("rsp_value", rsp_value, mon_e.val);
      end
    end
    prev_vld = rsp_valid;
  end

  always @(negedge clk) if (tx !== 1'b1) tx_low = 1;

  // Serial decoder on the DUT's tx line.
  always begin
    logic [7:0] b;
    int c0;
    @(negedge clk);
    if (tx === 1'b0) begin
      c0 = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      tx_log.push_back(b);
      tx_cyc.push_back(c0);
      rxq.push_back(b);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  // Behavioural threshold controller.
  initial begin
    logic [7:0] m, d;
    forever begin
      while (rxq.size() == 0) @(negedge clk);
      m = rxq.pop_front();
      if (ctl_mode == CTL_BAD_ECHO) begin
        send_byte(m + 8'd1);
      end else if (ctl_mode == CTL_SILENT) begin
        send_byte(m);
        while (rxq.size() == 0) @(negedge clk);
        d = rxq.pop_front();
      end else begin
        send_byte(m);
        while (rxq.size() == 0) @(negedge clk);
        d = rxq.pop_front();
        send_byte(d);
        if (ctl_mode == CTL_HANG) lsb_wait = 1;
        else begin
          send_byte(reply[7:0]);
          if (m == 8'h41) send_byte(reply[15:8]);
        end
      end
    end
  end

  task automatic handshake(input logic [7:0] mode, input logic dir, output int acc);
    int n;
    n = 0;
    req_mode = mode; req_dir = dir; req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("req_accepted", req_ready, 1);
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_mode = 8'($urandom);
    req_dir = 1'($urandom);
  endtask

  task automatic run_txn(input logic [7:0] mode, input logic dir, input int ctl);
    exp_t e;
    logic [7:0] exp_tx[$];
    int acc, c0, n, idx, nv;
    idx = int'(mode) - 'h41;
    exp_tx.delete();
    if (idx < 0 || idx > 6) begin
      e.st = 2'd3; e.val = 16'h0;
    end else begin
      exp_tx.push_back(mode);
      if (ctl == CTL_BAD_ECHO) begin
        e.st = 2'd1; e.val = 16'h0;
      end else begin
        exp_tx.push_back(dir ? 8'h77 : 8'h73);
        if (ctl == CTL_SILENT) begin
          e.st = 2'd2; e.val = 16'h0;
        end else begin
          nv = thr[idx] + (dir ? 1 : -1);
          if (nv < lo[idx]) nv = lo[idx];
          if (nv > hi[idx]) nv = hi[idx];
          thr[idx] = nv;
          reply = 16'(nv);
          e.st = 2'd0; e.val = 16'(nv);
        end
      end
    end
    ctl_mode = ctl;
    tx_log.delete(); tx_cyc.delete(); tx_low = 0;
    sbq.push_back(e);
    c0 = rsp_cnt;
    handshake(mode, dir, acc);
    n = 0;
    while (rsp_cnt == c0 && n < 5000) begin @(negedge clk); n++; end
    chk("rsp_arrived", rsp_cnt - c0, 1);
    repeat (30) @(negedge clk);
    chk("rsp_hold_status", rsp_status, e.st);
    chk("rsp_hold_value", rsp_value, e.val);
    chk("tx_byte_count", tx_log.size(), exp_tx.size());
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
      chk("tx_byte", tx_log[i], exp_tx[i]);
    if (e.st == 2'd3) begin
      chk("bad_mode_latency", rsp_cyc - acc, 1);
      chk("bad_mode_tx_quiet", tx_low, 0);
    end
    if (ctl == CTL_SILENT) begin
      if (tx_cyc.size() >= 2) chk("timeout_latency", rsp_cyc - tx_cyc[1], TMO);
      else chk("timeout_dir_sent", tx_cyc.size(), 2);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, c0, n;
    logic [7:0] m;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_status", rsp_status, 0);
    chk("reset_rsp_value", rsp_value, 0);
    chk("reset_tx_idle", tx, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);
    repeat (5) @(negedge clk);

    run_txn(8'h41, 1'b1, CTL_NORMAL);       // A up -> 0x0A28
    send_byte(8'h5A);                       // stray byte while idle
    repeat (20) @(negedge clk);
    run_txn(8'h43, 1'b0, CTL_NORMAL);       // C down from 16 -> 0x000F
    run_txn(8'h45, 1'b0, CTL_NORMAL);       // E at its -12 floor -> 0xFFF4
    run_txn(8'h42, 1'b1, CTL_BAD_ECHO);     // echo comes back as C
    run_txn(8'h44, 1'b1, CTL_SILENT);       // no dir echo -> timeout
    run_txn(8'h5A, 1'b1, CTL_NORMAL);       // "Z" -> bad mode

    // Reset while waiting for the threshold byte.
    ctl_mode = CTL_HANG; lsb_wait = 0;
    tx_log.delete(); tx_cyc.delete();
    c0 = rsp_cnt;
    handshake(8'h41, 1'b1, acc);
    n = 0;
    while (!lsb_wait && n < 5000) begin @(negedge clk); n++; end
    chk("hang_reached_lsb_wait", lsb_wait, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_rsp_status", rsp_status, 0);
    chk("midrst_tx_idle", tx, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_midrst", req_ready, 1);
    repeat (200) @(negedge clk);
    chk("no_rsp_after_abort", rsp_cnt - c0, 0);

    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        do m = 8'($urandom_range(0, 255)); while (m >= 8'h41 && m <= 8'h47);
      end else m = 8'(8'h41 + $urandom_range(0, 6));
      run_txn(m, 1'($urandom), CTL_NORMAL);
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/threshold_config_master.md
THRESHOLD_CONFIG_MASTER -- requirements
Module: threshold_config_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2000000, meaning the maximum clk cycles to wait for any single expected response byte.
REQ-002 SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1, command request strobe.
REQ-005 SHALL have port req_ready, output, 1, high when a request is accepted this cycle.
REQ-006 SHALL have port req_mode, input, 8, ASCII mode character "A".."G".
REQ-007 SHALL have port req_dir, input, 1, direction: 1 sends increment "w", 0 sends decrement "s".
REQ-008 SHALL have port rsp_valid, output, 1, one-cycle response pulse.
REQ-009 SHALL have port rsp_status, output, 2, response status: 0 OK, 1 echo mismatch, 2 timeout, 3 bad mode.
REQ-010 SHALL have port rsp_value, output, 16, returned threshold value.
REQ-011 SHALL have port rx, input, 1, serial line from the threshold controller.
REQ-012 SHALL have port tx, output, 1, serial line to the threshold controller.

Function
REQ-013 SHALL act as initiator for the threshold-configuration protocol: send mode byte, check echo, send direction byte, check echo, receive the updated threshold.
REQ-014 SHALL drive req_ready high only in state IDLE; a request transfers when req_valid and req_ready are both high.
REQ-015 SHALL, when req_mode is outside "A".."G", transmit nothing and pulse rsp_valid on the next cycle with status 3 and value 0.
REQ-016 SHALL use states IDLE, SEND_MODE, WAIT_MODE_ECHO, SEND_DIR, WAIT_DIR_ECHO, WAIT_LSB, WAIT_MSB, RESPOND.
REQ-017 SHALL register req_mode and req_dir at acceptance; later changes to the inputs have no effect on the transaction.
REQ-018 SHALL in SEND_MODE and SEND_DIR pulse the UART start_tx for exactly one cycle with the byte, only when idle_ready_tx is high, then advance to the matching WAIT state.
REQ-019 SHALL in WAIT_MODE_ECHO and WAIT_DIR_ECHO compare the first received byte with the byte sent.
  - Equal: advance to the next state.
  - Different: go to RESPOND with status 1.
REQ-020 SHALL in WAIT_LSB capture the first received byte.
  - Mode "A": advance to WAIT_MSB.
  - Any other mode: go to RESPOND with value = the byte sign-extended to 16 bits, status 0.
REQ-021 SHALL in WAIT_MSB form value = {msb, lsb} and go to RESPOND with status 0.
REQ-022 SHALL keep a timeout counter that clears on entry to every WAIT state and on every received byte; reaching TIMEOUT_CYCLES in a WAIT state goes to RESPOND with status 2 and value 0.
REQ-023 SHALL in RESPOND assert rsp_valid for one cycle with rsp_status and rsp_value stable, then return to IDLE.
REQ-024 SHALL hold rsp_status and rsp_value until the next rsp_valid pulse.
REQ-025 SHALL silently discard bytes received in IDLE, SEND_MODE or SEND_DIR.
REQ-026 SHALL, when a byte arrives on the same cycle the timeout is reached, take the byte and not the timeout.

Reset
REQ-027 SHALL on rst set state to IDLE, req_ready 0, rsp_valid 0, rsp_status 0, rsp_value 0, timeout counter 0, start_tx 0.
REQ-028 SHALL abort an in-flight transaction on rst with no rsp_valid pulse; tx returns to idle-high under the UART's own reset.

Structure
REQ-029 SHALL take the mode characters "A".."G", "w", "s", the status codes and the state encoding from a shared package also used by the threshold controller.
REQ-030 SHALL instantiate exactly one sub-module, the existing uart, for serialisation (data_tx, start_tx, idle_ready_tx, data_rx, data_ready_rx).

Verification
REQ-031 SHALL cover: default controller, request "A", dir 1 -> tx carries "A","w"; rx carries echoes then 0x28, 0x0A; rsp_value 0x0A28 (2600), status 0.
REQ-032 SHALL cover: request "C", dir 0 from value 16 -> rx returns 0x0F; rsp_value 0x000F, status 0.
REQ-033 SHALL cover: heatup threshold at -12, request "E", dir 0 -> rx returns 0xF4; rsp_value 0xFFF4, status 0.
REQ-034 SHALL cover: request "B" with echo returned as "C" -> status 1, no "w"/"s" transmitted.
REQ-035 SHALL cover: TIMEOUT_CYCLES=1000 and rx held idle after the mode echo -> status 2 exactly 1000 cycles after entering WAIT_DIR_ECHO; also req_mode "Z" -> status 3 and tx never toggles.
REQ-036 SHALL cover: rst asserted during WAIT_LSB -> no rsp_valid, req_ready high the cycle after rst deasserts.
